// File: rtl/param_memory_pkg.sv
// Shared types for the parametrised command-driven register memory.
package param_memory_pkg;

    // Sub-operations carried on op when write_en is the active request
    typedef enum logic [1:0] {
        WR_WRITE = 2'b00,
        WR_ADD   = 2'b01,
        WR_XOR   = 2'b10,
        WR_CLEAR = 2'b11
    } wr_op_e;

    // Sub-operations carried on op when read_en is the active request;
    // encodings 2'b10 and 2'b11 are illegal and get rejected
    typedef enum logic [1:0] {
        RD_READ  = 2'b00,
        RD_CLEAR = 2'b01
    } rd_op_e;

    // Command sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MODIFY = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/param_memory_alu.sv
// Combinational read-modify-write datapath: derives the new word value from
// the write sub-operation, the old word value and the command operand.
module param_memory_alu
    import param_memory_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] old_value,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] new_value
);

    // One extra bit so the carry out of the add is visible for clamping
    logic [DATA_W:0] sum;

    // Select the result for the requested write sub-operation
    always_comb begin
        sum       = {1'b0, old_value} + {1'b0, operand};
        new_value = '0;
        case (wr_op_e'(op))
            WR_WRITE: new_value = operand;
            WR_ADD: begin
                if ((SATURATE != 0) && sum[DATA_W]) begin
                    new_value = '1;
                end else begin
                    new_value = sum[DATA_W-1:0];
                end
            end
            WR_XOR:   new_value = old_value ^ operand;
            WR_CLEAR: new_value = '0;
            default:  new_value = '0;
        endcase
    end

endmodule

// File: rtl/param_memory.sv
// DEPTH x DATA_W register memory behind a single-port command interface with
// a ready handshake. Supports write/add/xor/clear, read and read-and-clear;
// illegal commands produce a one-cycle err pulse and leave memory untouched.
module param_memory
    import param_memory_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic              ready,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              err
);

    // One bit wider than the address so DEPTH == 2**ADDR_W is representable
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state;
    logic [1:0]        cap_op;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_old;
    logic [DATA_W-1:0] cap_wd;
    logic [DATA_W-1:0] alu_out;

    logic              cmd_seen;
    logic              cmd_reject;
    logic              cmd_rmw;
    logic              cmd_read;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign ready = (state == ST_IDLE) && !reset;

    param_memory_alu #(
        .DATA_W   (DATA_W),
        .SATURATE (SATURATE)
    ) u_alu (
        .op        (cap_op),
        .old_value (cap_old),
        .operand   (cap_wd),
        .new_value (alu_out)
    );

    // Decode the presented command and pick the single memory write source:
    // direct writes/clears in IDLE, or the RMW write-back while in MODIFY
    always_comb begin
        cmd_seen   = ready && (write_en || read_en);
        cmd_reject = cmd_seen &&
                     ((write_en && read_en) ||
                      ({1'b0, address} >= DEPTH_LIM) ||
                      (read_en && !write_en && op[1]));
        cmd_rmw    = cmd_seen && !cmd_reject && write_en &&
                     ((wr_op_e'(op) == WR_ADD) || (wr_op_e'(op) == WR_XOR));
        cmd_read   = cmd_seen && !cmd_reject && read_en;
        mem_we     = 1'b0;
        mem_waddr  = address;
        mem_wdata  = '0;
        if (state == ST_MODIFY) begin
            mem_we    = 1'b1;
            mem_waddr = cap_addr;
            mem_wdata = alu_out;
        end else if (cmd_seen && !cmd_reject) begin
            if (write_en && (wr_op_e'(op) == WR_WRITE)) begin
                mem_we    = 1'b1;
                mem_wdata = write_data;
            end else if (write_en && (wr_op_e'(op) == WR_CLEAR)) begin
                mem_we = 1'b1;
            end else if (read_en && (rd_op_e'(op) == RD_CLEAR)) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage array; reset wipes every word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Command FSM with registered read result, read_valid and err pulses.
    // Reset returns to IDLE, so an abandoned RMW never reaches write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cap_op     <= '0;
            cap_addr   <= '0;
            cap_old    <= '0;
            cap_wd     <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            read_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_seen) begin
                        if (cmd_reject) begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else if (cmd_rmw) begin
                            cap_op   <= op;
                            cap_addr <= address;
                            cap_old  <= mem[address];
                            cap_wd   <= write_data;
                            state    <= ST_MODIFY;
                        end else if (cmd_read) begin
                            read_data  <= mem[address];
                            read_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_MODIFY: state <= ST_DONE;
                ST_DONE:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench: two instances share one command stream. dut0 uses the
// default geometry with wrapping ADD; dut1 has DEPTH=6 and saturating ADD.
module tb_param_memory;

    localparam int NONE = -1;
    localparam int ERR  = -2;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_en;
    logic       read_en;
    logic [1:0] op;
    logic [2:0] address;
    logic [7:0] write_data;

    logic       ready0, read_valid0, err0;
    logic [7:0] read_data0;
    logic       ready1, read_valid1, err1;
    logic [7:0] read_data1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    param_memory #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
        .op(op), .address(address), .write_data(write_data),
        .ready(ready0), .read_data(read_data0), .read_valid(read_valid0),
        .err(err0)
    );

    param_memory #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .SATURATE(1)) dut1 (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
        .op(op), .address(address), .write_data(write_data),
        .ready(ready1), .read_data(read_data1), .read_valid(read_valid1),
        .err(err1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int which, input int e, input string name);
        exp_t x;
        if (e == NONE) return;
        x.is_err = (e == ERR);
        x.data   = (e == ERR) ? 8'h00 : e[7:0];
        x.name   = name;
        if (which == 0) q0.push_back(x);
        else            q1.push_back(x);
    endtask

    // Pops one expectation per presented output and compares it
    task automatic mon(input int which, input logic rv, input logic er,
                       input logic [7:0] d);
        exp_t x;
        string tag;
        tag = (which == 0) ? "dut0" : "dut1";
        if (rv || er) begin
            if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL %s unexpected output: rv=%0b err=%0b data=%0h required none",
                         tag, rv, er, d);
            end else begin
                x = (which == 0) ? q0.pop_front() : q1.pop_front();
                check({tag, " ", x.name, " err"}, 32'(er), 32'(x.is_err));
                check({tag, " ", x.name, " exclusive"}, 32'(rv && er), 32'd0);
                if (!x.is_err) check({tag, " ", x.name, " data"}, 32'(d), 32'(x.data));
            end
        end
    endtask

    // Issue one command at the current negedge; expected outputs per DUT
    task automatic cmd(input bit we, input bit re, input logic [1:0] o,
                       input logic [2:0] a, input logic [7:0] wd,
                       input int e0, input int e1, input int busy,
                       input string name, input bit hold);
        int n;
        check({name, " ready0 before"}, 32'(ready0), 32'd1);
        check({name, " ready1 before"}, 32'(ready1), 32'd1);
        push(0, e0, name);
        push(1, e1, name);
        write_en   = we;
        read_en    = re;
        op         = o;
        address    = a;
        write_data = wd;
        @(posedge clk);
        #1;
        if (!hold) begin
            write_en = 1'b0;
            read_en  = 1'b0;
        end
        n = 0;
        @(negedge clk);
        while (!ready0 && n < 8) begin
            n++;
            @(negedge clk);
        end
        check({name, " busy cycles"}, 32'(n), 32'(busy));
    endtask

    initial begin
        reset      = 1'b1;
        write_en   = 1'b0;
        read_en    = 1'b0;
        op         = 2'b00;
        address    = 3'd0;
        write_data = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    mon(0, read_valid0, err0, read_data0);
                    mon(1, read_valid1, err1, read_data1);
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) @(negedge clk);
        check("reset ready0", 32'(ready0), 32'd0);
        check("reset ready1", 32'(ready1), 32'd0);
        check("reset read_data0", 32'(read_data0), 32'h0);
        check("reset read_valid0", 32'(read_valid0), 32'd0);
        check("reset err0", 32'(err0), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        cmd(0, 1, 2'b00, 3'd5, 8'h00, 8'h00, 8'h00, 1, "read5 after reset", 0);

        cmd(1, 0, 2'b00, 3'd2, 8'hF0, NONE, NONE, 1, "write2 F0", 0);
        cmd(1, 0, 2'b01, 3'd2, 8'h20, NONE, NONE, 2, "add2 20", 0);
        cmd(0, 1, 2'b00, 3'd2, 8'h00, 8'h10, 8'hFF, 1, "read2 after add", 0);

        cmd(1, 0, 2'b00, 3'd2, 8'h55, NONE, NONE, 1, "write2 55", 0);
        check("read_data0 held over write", 32'(read_data0), 32'h10);
        check("read_data1 held over write", 32'(read_data1), 32'hFF);
        cmd(1, 0, 2'b10, 3'd2, 8'h0F, NONE, NONE, 2, "xor2 0F", 0);
        cmd(0, 1, 2'b01, 3'd2, 8'h00, 8'h5A, 8'h5A, 1, "read_clear2", 0);
        cmd(0, 1, 2'b00, 3'd2, 8'h00, 8'h00, 8'h00, 1, "read2 after clear", 0);

        cmd(1, 0, 2'b00, 3'd5, 8'h3C, NONE, NONE, 1, "write5 3C", 0);
        cmd(1, 0, 2'b00, 3'd7, 8'hAA, NONE, ERR, 1, "write7 AA", 0);
        cmd(0, 1, 2'b00, 3'd7, 8'h00, 8'hAA, ERR, 1, "read7", 0);
        cmd(1, 1, 2'b00, 3'd5, 8'hFF, ERR, ERR, 1, "both enables", 0);
        cmd(0, 1, 2'b00, 3'd5, 8'h00, 8'h3C, 8'h3C, 1, "read5 untouched", 0);
        cmd(0, 1, 2'b10, 3'd5, 8'h00, ERR, ERR, 1, "read op 10", 0);
        cmd(0, 1, 2'b11, 3'd5, 8'h00, ERR, ERR, 1, "read op 11", 0);
        cmd(1, 0, 2'b11, 3'd5, 8'h77, NONE, NONE, 1, "clear5", 0);
        cmd(0, 1, 2'b00, 3'd5, 8'h00, 8'h00, 8'h00, 1, "read5 after clear", 0);

        cmd(1, 0, 2'b00, 3'd1, 8'h70, NONE, NONE, 1, "write1 70", 0);
        cmd(1, 0, 2'b01, 3'd1, 8'h0F, NONE, NONE, 2, "add1 0F", 0);
        cmd(0, 1, 2'b00, 3'd1, 8'h00, 8'h7F, 8'h7F, 1, "read1 7F", 0);
        cmd(1, 0, 2'b01, 3'd1, 8'h80, NONE, NONE, 2, "add1 80", 0);
        cmd(0, 1, 2'b00, 3'd1, 8'h00, 8'hFF, 8'hFF, 1, "read1 FF", 0);
        cmd(1, 0, 2'b01, 3'd1, 8'h01, NONE, NONE, 2, "add1 01", 0);
        cmd(0, 1, 2'b00, 3'd1, 8'h00, 8'h00, 8'hFF, 1, "read1 overflow", 0);

        cmd(1, 0, 2'b00, 3'd3, 8'h11, NONE, NONE, 1, "held write3 11", 1);
        cmd(0, 1, 2'b00, 3'd3, 8'h00, 8'h11, 8'h11, 1, "held read3 11", 1);
        cmd(1, 0, 2'b00, 3'd3, 8'h22, NONE, NONE, 1, "held write3 22", 1);
        cmd(0, 1, 2'b00, 3'd3, 8'h00, 8'h22, 8'h22, 1, "held read3 22", 1);
        cmd(1, 0, 2'b00, 3'd6, 8'h99, NONE, ERR, 1, "held write6 99", 1);
        cmd(0, 1, 2'b00, 3'd6, 8'h00, 8'h99, ERR, 1, "held read6", 1);
        write_en = 1'b0;
        read_en  = 1'b0;

        cmd(1, 0, 2'b00, 3'd4, 8'h33, NONE, NONE, 1, "write4 33", 0);
        write_en   = 1'b1;
        op         = 2'b01;
        address    = 3'd4;
        write_data = 8'h11;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid-add reset ready0", 32'(ready0), 32'd0);
        check("mid-add reset ready1", 32'(ready1), 32'd0);
        @(negedge clk);
        check("mid-add reset ready0 held", 32'(ready0), 32'd0);
        check("mid-add reset read_data0", 32'(read_data0), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cmd(0, 1, 2'b00, 3'd4, 8'h00, 8'h00, 8'h00, 1, "read4 after reset", 0);
        cmd(0, 1, 2'b00, 3'd3, 8'h00, 8'h00, 8'h00, 1, "read3 after reset", 0);

        repeat (3) @(negedge clk);
        check("dut0 pending expectations", 32'(q0.size()), 32'd0);
        check("dut1 pending expectations", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
